// File: rtl/tt_um_richard28277.sv
// Registered 4-bit ALU Tiny Tapeout tile: 8-bit result on uo_out, C/Z/V/E flags on uio_out[7:4].
// Define ALU_DIV_EN to build the divider for opcode 3; otherwise opcode 3 reports an error like opcode 15.
module tt_um_richard28277 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_MUL  = 4'd2,
      OP_DIV  = 4'd3,
      OP_AND  = 4'd4,
      OP_OR   = 4'd5,
      OP_XOR  = 4'd6,
      OP_NOT  = 4'd7,
      OP_SHL  = 4'd8,
      OP_SHR  = 4'd9,
      OP_ROL  = 4'd10,
      OP_CMP  = 4'd11,
      OP_INC  = 4'd12,
      OP_DEC  = 4'd13,
      OP_PASS = 4'd14,
      OP_RSVD = 4'd15
   } op_e;

   logic [3:0] a;
   logic [3:0] b;
   op_e        op;

   assign a  = ui_in[3:0];
   assign b  = ui_in[7:4];
   assign op = op_e'(uio_in[3:0]);

   logic [7:0] alu_r;
   logic       alu_c;
   logic       alu_v;
   logic       alu_e;

   logic [4:0] sum5;
   logic [4:0] diff5;
   logic [7:0] prod8;
   logic [7:0] shl8;
   logic [7:0] shr8;
   logic [7:0] rol8;

   // Shared arithmetic: the carry/borrow falls out as bit 4 of a 5-bit add/subtract,
   // and shifts use a widened operand so the last bit shifted out lands in a fixed slot.
   always_comb begin
      sum5  = {1'b0, a} + {1'b0, b};
      diff5 = {1'b0, a} - {1'b0, b};
      prod8 = {4'b0, a} * {4'b0, b};
      shl8  = {4'b0, a} << b[1:0];
      shr8  = {a, 4'b0} >> b[1:0];
      rol8  = {a, a} << b[1:0];
   end

   // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
   always_comb begin
      alu_r = 8'h00;
      alu_c = 1'b0;
      alu_v = 1'b0;
      alu_e = 1'b0;
      unique case (op)
         OP_ADD: begin
            alu_r = {3'b0, sum5};
            alu_c = sum5[4];
            alu_v = (a[3] == b[3]) && (sum5[3] != a[3]);
         end
         OP_SUB: begin
            alu_r = {4'b0, diff5[3:0]};
            alu_c = diff5[4];
            alu_v = (a[3] != b[3]) && (diff5[3] != a[3]);
         end
         OP_MUL: alu_r = prod8;
         OP_DIV: begin
`ifdef ALU_DIV_EN
            if (b == 4'd0) begin
               alu_r = 8'hFF;
               alu_e = 1'b1;
            end else begin
               alu_r = {a % b, a / b};
            end
`else
            alu_e = 1'b1;
`endif
         end
         OP_AND:  alu_r = {4'b0, a & b};
         OP_OR:   alu_r = {4'b0, a | b};
         OP_XOR:  alu_r = {4'b0, a ^ b};
         OP_NOT:  alu_r = {4'b0, ~a};
         OP_SHL: begin
            alu_r = {4'b0, shl8[3:0]};
            alu_c = shl8[4];
         end
         OP_SHR: begin
            alu_r = {4'b0, shr8[7:4]};
            alu_c = shr8[3];
         end
         OP_ROL:  alu_r = {4'b0, rol8[7:4]};
         OP_CMP:  alu_r = {5'b0, a > b, a == b, a < b};
         OP_INC: begin
            alu_r = {4'b0, a + 4'd1};
            alu_c = (a == 4'hF);
         end
         OP_DEC: begin
            alu_r = {4'b0, a - 4'd1};
            alu_c = (a == 4'h0);
         end
         OP_PASS: alu_r = {b, a};
         OP_RSVD: alu_e = 1'b1;
         default: alu_e = 1'b1;
      endcase
   end

   logic [7:0] r_d, r_q;
   logic       c_d, c_q;
   logic       z_d, z_q;
   logic       v_d, v_q;
   logic       e_d, e_q;

   always_comb begin
      r_d = r_q;
      c_d = c_q;
      z_d = z_q;
      v_d = v_q;
      e_d = e_q;
      if (ena) begin
         r_d = alu_r;
         c_d = alu_c;
         z_d = (alu_r == 8'h00);
         v_d = alu_v;
         e_d = alu_e;
      end
   end

   // Reset is active-high despite the rst_n name, which is kept for the tile wrapper.
   // NOTE: state flops use non-blocking assignments so all of them sample pre-edge values together.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         r_q <= 8'h00;
         c_q <= 1'b0;
         z_q <= 1'b1;
         v_q <= 1'b0;
         e_q <= 1'b0;
      end else begin
         r_q <= r_d;
         c_q <= c_d;
         z_q <= z_d;
         v_q <= v_d;
         e_q <= e_d;
      end
   end

   assign uo_out  = r_q;
   assign uio_out = {e_q, v_q, z_q, c_q, 4'b0000};
   assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_richard28277.sv
// Self-checking bench for tt_um_richard28277: a per-cycle arithmetic reference model plus
// directed vectors with hand-computed results.
module tb_tt_um_richard28277;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int n_total;
   int n_pass;

   tt_um_richard28277 dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
   endtask

   // Reference model: spec rules in integer arithmetic; returns {flags[7:4],4'b0,R}.
   function automatic logic [15:0] model(input int a, input int b, input int op);
      int r, c, v, e, s, sa, sb, t;
      r = 0; c = 0; v = 0; e = 0;
      s  = b % 4;
      sa = (a >= 8) ? a - 16 : a;
      sb = (b >= 8) ? b - 16 : b;
      case (op)
         0: begin
            r = a + b; c = (r >= 16) ? 1 : 0;
            t = sa + sb; v = (t > 7 || t < -8) ? 1 : 0;
         end
         1: begin
            r = (a - b + 16) % 16; c = (a < b) ? 1 : 0;
            t = sa - sb; v = (t > 7 || t < -8) ? 1 : 0;
         end
         2: r = a * b;
         3: begin
`ifdef ALU_DIV_EN
            if (b == 0) begin r = 255; e = 1; end
            else r = (a % b) * 16 + (a / b);
`else
            e = 1;
`endif
         end
         4: r = a & b;
         5: r = a | b;
         6: r = a ^ b;
         7: r = 15 - a;
         8: begin
            r = (a * (1 << s)) % 16;
            c = (s == 0) ? 0 : ((a * (1 << s)) / 16) % 2;
         end
         9: begin
            r = a / (1 << s);
            c = (s == 0) ? 0 : (a / (1 << (s - 1))) % 2;
         end
         10: r = ((a * (1 << s)) % 16) + (a / (1 << (4 - s)));
         11: r = (a > b) ? 4 : (a == b) ? 2 : 1;
         12: begin r = (a + 1) % 16; c = (a == 15) ? 1 : 0; end
         13: begin r = (a + 15) % 16; c = (a == 0) ? 1 : 0; end
         14: r = b * 16 + a;
         default: e = 1;
      endcase
      model = 16'(e * 32768 + v * 16384 + ((r == 0) ? 8192 : 0) + c * 4096 + r);
   endfunction

   logic [15:0] exp_q;

   always @(posedge clk or posedge rst_n) begin
      if (rst_n) exp_q = 16'h2000;
      else if (ena) exp_q = model(int'(ui_in[3:0]), int'(ui_in[7:4]), int'(uio_in[3:0]));
   end

   always @(negedge clk) begin
      check("cycle_out", {uio_out[7:4], 4'h0, uo_out}, exp_q);
      check("cycle_oe", {8'h00, uio_oe}, 16'h00F0);
   end

   task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
      @(negedge clk);
      ui_in  = {b, a};
      uio_in = {4'h0, op};
      @(posedge clk);
      #1;
   endtask

   task automatic op_check(input string name, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] op, input logic [7:0] r, input logic [7:0] fl);
      apply(a, b, op);
      check(name, {uio_out, uo_out}, {fl, r});
   endtask

   logic [15:0] held;

   initial begin
      n_total = 0;
      n_pass  = 0;
      rst_n   = 1'b1;
      ena     = 1'b1;
      ui_in   = 8'h00;
      uio_in  = 8'h00;
      #22;
      check("reset_r", {8'h00, uo_out}, 16'h0000);
      check("reset_flags", {8'h00, uio_out}, 16'h0020);
      @(negedge clk);
      rst_n = 1'b0;

      // Model spot checks against hand-computed values.
      check("model_add", model(9, 8, 0), 16'h5011);
      check("model_shl", model(10, 6, 8), 16'h0008);
      check("model_shr", model(10, 2, 9), 16'h1002);
      check("model_rol", model(10, 1, 10), 16'h0005);

      op_check("add", 4'h9, 4'h8, 4'd0, 8'h11, 8'h50);
      op_check("add_small", 4'h2, 4'h3, 4'd0, 8'h05, 8'h00);
      op_check("sub", 4'h3, 4'h5, 4'd1, 8'h0E, 8'h10);
      op_check("mul", 4'hF, 4'hF, 4'd2, 8'hE1, 8'h00);
`ifdef ALU_DIV_EN
      op_check("div", 4'hD, 4'h4, 4'd3, 8'h13, 8'h00);
      op_check("div0", 4'hD, 4'h0, 4'd3, 8'hFF, 8'h80);
`else
      op_check("div", 4'hD, 4'h4, 4'd3, 8'h00, 8'hA0);
      op_check("div0", 4'hD, 4'h0, 4'd3, 8'h00, 8'hA0);
`endif
      op_check("and", 4'hA, 4'h6, 4'd4, 8'h02, 8'h00);
      op_check("or", 4'hA, 4'h6, 4'd5, 8'h0E, 8'h00);
      op_check("xor", 4'hA, 4'h6, 4'd6, 8'h0C, 8'h00);
      op_check("not", 4'hA, 4'h6, 4'd7, 8'h05, 8'h00);
      op_check("shl", 4'hA, 4'h6, 4'd8, 8'h08, 8'h00);
      op_check("shl0", 4'hA, 4'h4, 4'd8, 8'h0A, 8'h00);
      op_check("shr", 4'hA, 4'h2, 4'd9, 8'h02, 8'h10);
      op_check("rol", 4'hA, 4'h1, 4'd10, 8'h05, 8'h00);
      op_check("cmp_eq", 4'h7, 4'h7, 4'd11, 8'h02, 8'h00);
      op_check("cmp_gt", 4'h8, 4'h7, 4'd11, 8'h04, 8'h00);
      op_check("inc", 4'hF, 4'h0, 4'd12, 8'h00, 8'h30);
      op_check("dec", 4'h0, 4'h0, 4'd13, 8'h0F, 8'h10);
      op_check("pass", 4'h3, 4'hC, 4'd14, 8'hC3, 8'h00);
      op_check("rsvd", 4'h3, 4'hC, 4'd15, 8'h00, 8'hA0);

      // Sweep a few operand pairs through every opcode; the per-cycle compare checks them.
      for (int op = 0; op < 16; op++) begin
         apply(4'h5, 4'hB, 4'(op));
         apply(4'hE, 4'h3, 4'(op));
         apply(4'h8, 4'h8, 4'(op));
      end

      // Enable hold
      op_check("pre_hold", 4'h3, 4'hC, 4'd14, 8'hC3, 8'h00);
      held = {uio_out, uo_out};
      @(negedge clk);
      ena = 1'b0;
      apply(4'h9, 4'h8, 4'd0);
      check("hold1", {uio_out, uo_out}, 16'h00C3);
      apply(4'hF, 4'hF, 4'd2);
      apply(4'h0, 4'h0, 4'd15);
      check("hold3", {uio_out, uo_out}, held);
      @(negedge clk);
      ena = 1'b1;
      @(posedge clk);
      #1;
      check("ena_update", {uio_out, uo_out}, 16'hA000);

      // Asynchronous reset mid-cycle
      apply(4'h9, 4'h8, 4'd0);
      rst_n = 1'b1;
      #1;
      check("async_rst_r", {8'h00, uo_out}, 16'h0000);
      check("async_rst_flags", {8'h00, uio_out}, 16'h0020);
      check("async_rst_oe", {8'h00, uio_oe}, 16'h00F0);
      @(negedge clk);
      rst_n = 1'b0;
      op_check("post_rst", 4'hF, 4'hF, 4'd2, 8'hE1, 8'h00);

      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
